pwm_ramp_ctrl: RTL and testbench

- Avalon-MM write master that programs and sequences the 3-register PWM peripheral (addr 0 = div, 1 = duty, 2 = dead-time).
- On start it writes div and dt, then ramps duty from its current value toward a target in fixed steps, one write every cfg_interval cycles. This gives soft-start and soft-stop of the 8-channel PWM outputs.
- Sits between the control CPU registers and the PWM slave port.
- abort forces a safe duty = 0 write.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_av_wr_port.sv | 59 +++++
 rtl/pwm_ramp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM ramp controller.
//   - PWM slave register map (div, duty, dead-time)
//   - controller state encoding
//   - data path width
package pwm_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] PWM_ADDR_DIV  = 2'd0;
    localparam logic [1:0] PWM_ADDR_DUTY = 2'd1;
    localparam logic [1:0] PWM_ADDR_DT   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        WR_DIV,
        WR_DT,
        CALC,
        WR_DUTY,
        WAIT,
        WR_ZERO,
        DONE
    } state_t;

endpackage

// File: rtl/pwm_av_wr_port.sv
// pwm_av_wr_port: single-beat Avalon-MM write master port.
// Registers the request presented for the next cycle onto the bus and holds it
// while the slave stalls.
// Ports:
//   i_clk, i_clr      clock, asynchronous active-high reset
//   i_req             drive a write in the next cycle
//   i_addr, i_data    address / data of that write
//   i_waitrequest     slave stall
//   o_cs, o_wr_n      chip select, active-low write strobe
//   o_addr, o_wr_data bus address / data
//   o_accept          current write is taken at the coming clock edge
module pwm_av_wr_port
    import pwm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_req,
    input  logic [1:0]        i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_waitrequest,
    output logic              o_cs,
    output logic              o_wr_n,
    output logic [1:0]        o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_accept
);

    logic              r_cs;
    logic              r_wr_n;
    logic [1:0]        r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_stall;

    assign w_stall  = r_cs & i_waitrequest;
    assign o_accept = r_cs & ~i_waitrequest;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cs   <= 1'b0;
            r_wr_n <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else if (!w_stall) begin
            r_cs   <= i_req;
            r_wr_n <= ~i_req;
            // Address/data keep their last value between writes.
            if (i_req) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    assign o_cs      = r_cs;
    assign o_wr_n    = r_wr_n;
    assign o_addr    = r_addr;
    assign o_wr_data = r_data;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: programs the PWM peripheral (div, dead-time) and ramps its
// duty register toward a target in fixed steps, one write per interval.
// Ports:
//   i_clk, i_clr            clock, asynchronous active-high reset
//   i_start, i_abort        begin sequence / force duty to 0 (abort wins)
//   i_cfg_*                 period, dead-time, target duty, step, interval
//   o_av_*, i_av_waitrequest Avalon-MM write master to the PWM slave
//   o_busy                  not idle
//   o_done, o_aborted       one-cycle completion pulses
//   o_cur_duty              last duty value accepted by the slave
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned INTERVAL_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_W-1:0]     i_cfg_div,
    input  logic [DATA_W-1:0]     i_cfg_dt,
    input  logic [DATA_W-1:0]     i_cfg_target,
    input  logic [DATA_W-1:0]     i_cfg_step,
    input  logic [INTERVAL_W-1:0] i_cfg_interval,
    output logic                  o_av_cs,
    output logic                  o_av_wr_n,
    output logic [1:0]            o_av_addr,
    output logic [DATA_W-1:0]     o_av_wr_data,
    input  logic                  i_av_waitrequest,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic [DATA_W-1:0]     o_cur_duty
);

    state_t                r_state, w_state_d;
    logic [DATA_W-1:0]     r_div, r_dt, r_tgt, r_step, r_next, r_cur;
    logic [INTERVAL_W-1:0] r_interval, r_cnt;
    logic                  r_abort_pend, r_busy, r_done, r_aborted;

    logic                  w_accept, w_abort, w_req;
    logic [1:0]            w_addr;
    logic [DATA_W-1:0]     w_data, w_calc;
    logic [DATA_W:0]       w_sum;

    // An abort seen during a stalled write is remembered until that write lands.
    assign w_abort = i_abort | r_abort_pend;

    // Next duty value; 33-bit sum so a large step cannot wrap past the target.
    always_comb begin
        w_sum = {1'b0, r_cur} + {1'b0, r_step};
        if (r_cur < r_tgt) begin
            w_calc = (w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[DATA_W-1:0];
        end else if ((r_cur < r_step) || ((r_cur - r_step) < r_tgt)) begin
            w_calc = r_tgt;
        end else begin
            w_calc = r_cur - r_step;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (i_abort) w_state_d = WR_ZERO;
                     else if (i_start) w_state_d = WR_DIV;
            WR_DIV:  if (w_accept) w_state_d = w_abort ? WR_ZERO : WR_DT;
            WR_DT:   if (w_accept) w_state_d = w_abort ? WR_ZERO : CALC;
            CALC:    if (w_abort) w_state_d = WR_ZERO;
                     else if (r_cur == r_tgt) w_state_d = DONE;
                     else w_state_d = WR_DUTY;
            WR_DUTY: if (w_accept) begin
                         if (w_abort) w_state_d = WR_ZERO;
                         else if (r_next == r_tgt) w_state_d = DONE;
                         else if (r_interval == '0) w_state_d = CALC;
                         else w_state_d = WAIT;
                     end
            WAIT:    if (w_abort) w_state_d = WR_ZERO;
                     else if (r_cnt <= INTERVAL_W'(1)) w_state_d = CALC;
            WR_ZERO: if (w_accept) w_state_d = IDLE;
            DONE:    w_state_d = w_abort ? WR_ZERO : IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Bus request for the cycle after this edge, derived from the next state so
    // the write appears in the same cycle the FSM enters a write state.
    always_comb begin
        w_req  = 1'b0;
        w_addr = PWM_ADDR_DIV;
        w_data = '0;
        unique case (w_state_d)
            WR_DIV: begin
                w_req  = 1'b1;
                w_addr = PWM_ADDR_DIV;
                w_data = (r_state == IDLE) ? i_cfg_div : r_div;
            end
            WR_DT: begin
                w_req  = 1'b1;
                w_addr = PWM_ADDR_DT;
                w_data = r_dt;
            end
            WR_DUTY: begin
                w_req  = 1'b1;
                w_addr = PWM_ADDR_DUTY;
                w_data = (r_state == CALC) ? w_calc : r_next;
            end
            WR_ZERO: begin
                w_req  = 1'b1;
                w_addr = PWM_ADDR_DUTY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state      <= IDLE;
            r_div        <= '0;
            r_dt         <= '0;
            r_tgt        <= '0;
            r_step       <= '0;
            r_next       <= '0;
            r_cur        <= '0;
            r_interval   <= '0;
            r_cnt        <= '0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_busy    <= (w_state_d != IDLE);
            r_done    <= (w_state_d == DONE);
            r_aborted <= (r_state == WR_ZERO) && w_accept;
            r_abort_pend <= w_abort &&
                            (w_state_d inside {WR_DIV, WR_DT, WR_DUTY});

            if ((r_state == IDLE) && i_start && !i_abort) begin
                r_div      <= i_cfg_div;
                r_dt       <= i_cfg_dt;
                r_tgt      <= (i_cfg_target < i_cfg_div) ? i_cfg_target : i_cfg_div;
                r_step     <= (i_cfg_step == '0) ? DATA_W'(1) : i_cfg_step;
                r_interval <= i_cfg_interval;
            end

            if (r_state == CALC) begin
                r_next <= w_calc;
            end

            if ((r_state == WR_DUTY) && w_accept) begin
                r_cur <= r_next;
                r_cnt <= r_interval;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - INTERVAL_W'(1);
            end else if ((r_state == WR_ZERO) && w_accept) begin
                r_cur <= '0;
            end
        end
    end

    pwm_av_wr_port u_wr_port (
        .i_clk         (i_clk),
        .i_clr         (i_clr),
        .i_req         (w_req),
        .i_addr        (w_addr),
        .i_data        (w_data),
        .i_waitrequest (i_av_waitrequest),
        .o_cs          (o_av_cs),
        .o_wr_n        (o_av_wr_n),
        .o_addr        (o_av_addr),
        .o_wr_data     (o_av_wr_data),
        .o_accept      (w_accept)
    );

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_aborted  = r_aborted;
    assign o_cur_duty = r_cur;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: table-driven ramp sequences plus hand-written
// stall, abort and asynchronous-reset sequences.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        waitreq = 1'b0;
    logic [31:0] cfg_div = '0, cfg_dt = '0, cfg_target = '0, cfg_step = '0;
    logic [15:0] cfg_interval = '0;
    logic        av_cs, av_wr_n, busy, done, aborted;
    logic [1:0]  av_addr;
    logic [31:0] av_wr_data, cur_duty;

    pwm_ramp_ctrl #(.INTERVAL_W(16)) dut (
        .i_clk            (clk),
        .i_clr            (clr),
        .i_start          (start),
        .i_abort          (abort),
        .i_cfg_div        (cfg_div),
        .i_cfg_dt         (cfg_dt),
        .i_cfg_target     (cfg_target),
        .i_cfg_step       (cfg_step),
        .i_cfg_interval   (cfg_interval),
        .o_av_cs          (av_cs),
        .o_av_wr_n        (av_wr_n),
        .o_av_addr        (av_addr),
        .o_av_wr_data     (av_wr_data),
        .i_av_waitrequest (waitreq),
        .o_busy           (busy),
        .o_done           (done),
        .o_aborted        (aborted),
        .o_cur_duty       (cur_duty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    typedef struct packed {
        logic [31:0]      div, dt, tgt, step;
        logic [15:0]      interval;
        logic [31:0]      n_duty;
        logic [0:3][31:0] duty;
        logic [31:0]      fin;
    } vec_t;

    wr_t  wlog[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   abort_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[5];

    // Bus monitor: values read here are those present just before the edge.
    always @(posedge clk) begin
        if (av_cs && !av_wr_n && !waitreq) wlog.push_back({av_addr, av_wr_data, cyc[31:0]});
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        cyc++;
    end

    function automatic vec_t mk(input logic [31:0] div, dt, tgt, step,
                                input logic [15:0] iv,
                                input logic [31:0] n, d0, d1, d2, d3, fin);
        vec_t v;
        v.div = div; v.dt = dt; v.tgt = tgt; v.step = step; v.interval = iv;
        v.n_duty = n; v.duty[0] = d0; v.duty[1] = d1; v.duty[2] = d2; v.duty[3] = d3;
        v.fin = fin;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [1:0] addr,
                          input logic [31:0] data, input int c);
        checks++;
        if (idx >= wlog.size()) begin
            failures++;
            $display("FAIL %s: got no write expected addr %0d data %0d cycle %0d",
                     nm, addr, data, c);
        end else if (wlog[idx].addr !== addr || wlog[idx].data !== data ||
                     wlog[idx].cyc !== c) begin
            failures++;
            $display("FAIL %s: got addr %0d data %0d cycle %0d expected addr %0d data %0d cycle %0d",
                     nm, wlog[idx].addr, wlog[idx].data, wlog[idx].cyc, addr, data, c);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " idle timeout"}, (n >= 500) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
    endtask

    // Wait (bounded) for a given write to be on the bus.
    task automatic wait_write(input string nm, input logic [31:0] data);
        int n = 0;
        while (!(av_cs && av_addr == 2'd1 && av_wr_data == data) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " write seen"}, (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic set_cfg(input logic [31:0] div, dt, tgt, step, input logic [15:0] iv);
        cfg_div = div; cfg_dt = dt; cfg_target = tgt; cfg_step = step; cfg_interval = iv;
    endtask

    task automatic run_row(input vec_t v, input int id);
        int    s;
        string nm;
        nm = $sformatf("row%0d", id);
        set_cfg(v.div, v.dt, v.tgt, v.step, v.interval);
        wlog.delete();
        done_cnt = 0;
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Later config edits must not disturb the running sequence.
        cfg_target = 32'd7;
        cfg_step = 32'd99;
        wait_idle(nm);
        chk({nm, " nwrites"}, wlog.size(), 2 + v.n_duty);
        chk_wr({nm, " div"}, 0, 2'd0, v.div, s + 1);
        chk_wr({nm, " dt"}, 1, 2'd2, v.dt, s + 2);
        for (int k = 0; k < int'(v.n_duty); k++) begin
            chk_wr($sformatf("%s duty%0d", nm, k), k + 2, 2'd1, v.duty[k],
                   s + 4 + k * (int'(v.interval) + 2));
        end
        chk({nm, " done pulses"}, done_cnt, 1);
        chk({nm, " cur_duty"}, cur_duty, v.fin);
        chk({nm, " busy"}, busy, 0);
    endtask

    initial begin
        int s;
        tbl[0] = mk(100, 3, 40, 10, 5, 4, 10, 20, 30, 40, 40);   // ramp up
        tbl[1] = mk(100, 3, 15, 10, 2, 3, 30, 20, 15, 0, 15);    // ramp down, clamp at target
        tbl[2] = mk(100, 7, 500, 50, 0, 2, 65, 100, 0, 0, 100);  // target clamped to div
        tbl[3] = mk(100, 3, 3, 0, 1, 3, 1, 2, 3, 0, 3);          // step 0 acts as 1
        tbl[4] = mk(100, 3, 3, 0, 1, 0, 0, 0, 0, 0, 3);          // already at target

        #1 clr = 1'b1;
        #2;
        chk("rst cs", av_cs, 0);
        chk("rst wr_n", av_wr_n, 1);
        chk("rst addr", av_addr, 0);
        chk("rst data", av_wr_data, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst aborted", aborted, 0);
        chk("rst cur_duty", cur_duty, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_row(tbl[i], i);

        // Abort together with start in IDLE: only the zero write happens.
        wlog.delete();
        abort_cnt = 0;
        s = cyc;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        wait_idle("idle abort");
        chk("idle abort nwrites", wlog.size(), 1);
        chk_wr("idle abort zero", 0, 2'd1, 0, s + 1);
        chk("idle abort pulses", abort_cnt, 1);
        chk("idle abort cur_duty", cur_duty, 0);

        for (int i = 3; i < 5; i++) run_row(tbl[i], i);

        // Stall the second duty write (23) for four edges.
        set_cfg(100, 3, 30, 10, 2);
        wlog.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_write("stall", 32'd23);
        waitreq = 1'b1;
        chk("stall pre cur_duty", cur_duty, 13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d cs", i), av_cs, 1);
            chk($sformatf("stall%0d addr", i), av_addr, 1);
            chk($sformatf("stall%0d data", i), av_wr_data, 23);
            chk($sformatf("stall%0d cur_duty", i), cur_duty, 13);
        end
        waitreq = 1'b0;
        @(negedge clk);
        chk("stall accept cur_duty", cur_duty, 23);
        wait_idle("stall");
        chk("stall nwrites", wlog.size(), 5);
        chk("stall final cur_duty", cur_duty, 30);

        // Abort during a stalled duty write: that write lands, then (1,0).
        set_cfg(100, 3, 60, 10, 2);
        wlog.delete();
        done_cnt = 0;
        abort_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_write("abort", 32'd40);
        waitreq = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort hold data", av_wr_data, 40);
        chk("abort hold cur_duty", cur_duty, 30);
        waitreq = 1'b0;
        @(negedge clk);
        wait_idle("abort");
        chk("abort nwrites", wlog.size(), 4);
        if (wlog.size() >= 3) chk_wr("abort pending", 2, 2'd1, 40, wlog[2].cyc);
        if (wlog.size() >= 4) chk_wr("abort zero", 3, 2'd1, 0, wlog[2].cyc + 1);
        chk("abort pulses", abort_cnt, 1);
        chk("abort done pulses", done_cnt, 0);
        chk("abort cur_duty", cur_duty, 0);
        chk("abort busy", busy, 0);

        // Asynchronous reset while waiting between duty writes.
        set_cfg(100, 3, 40, 10, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (cur_duty != 32'd10 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("areset reach wait", (n >= 100) ? 32'd1 : 32'd0, 0);
        end
        @(negedge clk);
        chk("areset pre busy", busy, 1);
        #2 clr = 1'b1;
        #1;
        chk("areset cs", av_cs, 0);
        chk("areset wr_n", av_wr_n, 1);
        chk("areset addr", av_addr, 0);
        chk("areset data", av_wr_data, 0);
        chk("areset busy", busy, 0);
        chk("areset done", done, 0);
        chk("areset aborted", aborted, 0);
        chk("areset cur_duty", cur_duty, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        run_row(tbl[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
